// File: rtl/ram_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_scan_pkg
//  Purpose  : Shared constants and FSM state type for the RAM scanner.
//             Holds the default RAM geometry, the checksum width and the
//             PAUSE/RUN state encoding used by m_ram_scanner.
//  Revision : 1.0  initial release
// ============================================================================
package ram_scan_pkg;

    // Default RAM geometry (64 x 4) and checksum width
    localparam int unsigned c_adr_w_dflt = 6;
    localparam int unsigned c_dat_w_dflt = 4;
    localparam int unsigned c_chk_w      = 8;

    // Scanner state, explicitly one bit wide
    typedef enum logic [0:0] {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage : ram_scan_pkg
`default_nettype wire

// File: rtl/m_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : m_rise_detect
//  Purpose  : One-cycle pulse on a 0->1 transition of a debounced level.
//             The history register is cleared by reset, and the detector
//             stays disarmed for the first cycle after reset so a button
//             held through reset does not generate an edge.
//  Ports    : clk    in   system clock
//             rst    in   synchronous active-high reset
//             i_lvl  in   debounced level
//             o_rise out  1-cycle pulse on rising edge of i_lvl
//  Revision : 1.0  initial release
// ============================================================================
module m_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_hist;
    logic r_arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 1'b0;
            r_arm  <= 1'b0;
        end else begin
            r_hist <= i_lvl;
            r_arm  <= 1'b1;
        end
    end

    // r_arm masks the first post-reset cycle, where r_hist is still 0 even
    // if the button was held down during reset.
    assign o_rise = i_lvl & ~r_hist & r_arm;

endmodule : m_rise_detect
`default_nettype wire

// File: rtl/m_ram_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : m_ram_scanner
//  Purpose  : Reader side of the switch-written RAM. Walks the RAM address
//             space and presents registered address/data to the display
//             path. Modes: auto-run at a fixed tick rate, pause,
//             single-step and direct load.
//  Config   : RAM_SCAN_CHECKSUM_EN - when defined, an 8-bit sweep checksum
//             is accumulated and published on every wrap (chk_sum/chk_vld);
//             when undefined both outputs are tied to 0.
//  Ports    : clk        in   system clock
//             rst        in   synchronous active-high reset
//             btn_run    in   debounced level, rise toggles RUN/PAUSE
//             btn_step   in   debounced level, rise steps one address in PAUSE
//             load_en    in   level, forces address to load_adr, enters PAUSE
//             load_adr   in   address to load
//             ram_adr    out  RAM asynchronous read address
//             ram_rdata  in   RAM read data (combinational from ram_adr)
//             cur_adr    out  displayed address (registered)
//             cur_data   out  displayed data (registered)
//             data_vld   out  cur_data corresponds to the settled address
//             running    out  1 while in RUN
//             sweep_done out  1-cycle pulse when the address wraps to 0
//             chk_sum    out  sweep checksum
//             chk_vld    out  chk_sum valid
//  Revision : 1.0  initial release
// ============================================================================
module m_ram_scanner
    import ram_scan_pkg::*;
#(
    parameter int unsigned ADR_W    = c_adr_w_dflt,
    parameter int unsigned DAT_W    = c_dat_w_dflt,
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               load_en,
    input  logic [ADR_W-1:0]   load_adr,
    output logic [ADR_W-1:0]   ram_adr,
    input  logic [DAT_W-1:0]   ram_rdata,
    output logic [ADR_W-1:0]   cur_adr,
    output logic [DAT_W-1:0]   cur_data,
    output logic               data_vld,
    output logic               running,
    output logic               sweep_done,
    output logic [c_chk_w-1:0] chk_sum,
    output logic               chk_vld
);

    localparam int unsigned         c_tick_w    = $clog2(TICK_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [ADR_W-1:0]    c_adr_last  = '1;

    logic                w_run_rise;
    logic                w_step_rise;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tick_w-1:0] r_tick;
    logic [c_tick_w-1:0] w_tick_nxt;
    logic [ADR_W-1:0]    r_adr;
    logic [ADR_W-1:0]    w_adr_nxt;
    logic                w_adv;
    logic                w_wrap;

    logic [ADR_W-1:0]    r_cur_adr;
    logic [DAT_W-1:0]    r_cur_data;
    logic                r_data_vld;
    logic                r_sweep_done;

    // ------------------------------------------------------------------
    // Button edge detectors
    // ------------------------------------------------------------------
    m_rise_detect u_run_edge (
        .clk    (clk),
        .rst    (rst),
        .i_lvl  (btn_run),
        .o_rise (w_run_rise)
    );

    m_rise_detect u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .i_lvl  (btn_step),
        .o_rise (w_step_rise)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PAUSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, prescaler and address advance.
    // Priority: load_en > run toggle > step/tick advance. A run edge
    // coinciding with a step edge toggles only.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_adr_nxt   = r_adr;
        w_adv       = 1'b0;
        w_wrap      = 1'b0;

        if (load_en) begin
            w_state_nxt = S_PAUSE;
            w_tick_nxt  = '0;
            w_adr_nxt   = load_adr;
        end else if (w_run_rise) begin
            w_state_nxt = (r_state == S_RUN) ? S_PAUSE : S_RUN;
            w_tick_nxt  = '0;
        end else if (r_state == S_RUN) begin
            if (r_tick == c_tick_last) begin
                w_tick_nxt = '0;
                w_adv      = 1'b1;
            end else begin
                w_tick_nxt = r_tick + c_tick_w'(1);
            end
        end else if (w_step_rise) begin
            w_adv = 1'b1;
        end

        if (w_adv) begin
            w_adr_nxt = r_adr + ADR_W'(1);
            w_wrap    = (r_adr == c_adr_last);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick       <= '0;
            r_adr        <= '0;
            r_cur_adr    <= '0;
            r_cur_data   <= '0;
            r_data_vld   <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_tick       <= w_tick_nxt;
            r_adr        <= w_adr_nxt;
            r_cur_adr    <= r_adr;
            r_cur_data   <= ram_rdata;
            // While r_adr holds a freshly changed value the display
            // registers still show the previous address.
            r_data_vld   <= (w_adr_nxt == r_adr);
            r_sweep_done <= w_wrap;
        end
    end

    assign ram_adr    = r_adr;
    assign cur_adr    = r_cur_adr;
    assign cur_data   = r_cur_data;
    assign data_vld   = r_data_vld;
    assign running    = (r_state == S_RUN);
    assign sweep_done = r_sweep_done;

    // ------------------------------------------------------------------
    // Optional sweep checksum
    // ------------------------------------------------------------------
`ifdef RAM_SCAN_CHECKSUM_EN
    logic [c_chk_w-1:0] r_acc;
    logic [c_chk_w-1:0] r_chk_sum;
    logic               r_chk_vld;
    logic               r_clean;     // current sweep started at 0 with no load
    logic [c_chk_w-1:0] w_dat_ext;

    assign w_dat_ext = c_chk_w'(ram_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_chk_sum <= '0;
            r_chk_vld <= 1'b0;
            r_clean   <= 1'b1;
        end else if (load_en) begin
            r_acc     <= '0;
            r_chk_vld <= 1'b0;
            r_clean   <= 1'b0;
        end else if (w_wrap) begin
            // Data still belongs to the last address of the sweep here.
            if (r_clean) begin
                r_chk_sum <= r_acc + w_dat_ext;
                r_chk_vld <= 1'b1;
            end
            r_acc   <= '0;
            r_clean <= 1'b1;
        end else if (w_adv) begin
            r_acc <= r_acc + w_dat_ext;
        end
    end

    assign chk_sum = r_chk_sum;
    assign chk_vld = r_chk_vld;
`else
    assign chk_sum = '0;
    assign chk_vld = 1'b0;
`endif

endmodule : m_ram_scanner
`default_nettype wire

// File: tb/tb_m_ram_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_ram_scanner
//  Purpose  : Directed self-checking bench for m_ram_scanner with
//             TICK_DIV=4 and a 64x4 RAM model holding mem[i] = i mod 16.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_ram_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_step;
    logic       load_en;
    logic [5:0] load_adr;
    logic [5:0] ram_adr;
    logic [3:0] ram_rdata;
    logic [5:0] cur_adr;
    logic [3:0] cur_data;
    logic       data_vld;
    logic       running;
    logic       sweep_done;
    logic [7:0] chk_sum;
    logic       chk_vld;

    logic [3:0] mem [64];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'(i % 16);
    end

    assign ram_rdata = mem[ram_adr];

    m_ram_scanner #(
        .ADR_W    (6),
        .DAT_W    (4),
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .load_en    (load_en),
        .load_adr   (load_adr),
        .ram_adr    (ram_adr),
        .ram_rdata  (ram_rdata),
        .cur_adr    (cur_adr),
        .cur_data   (cur_data),
        .data_vld   (data_vld),
        .running    (running),
        .sweep_done (sweep_done),
        .chk_sum    (chk_sum),
        .chk_vld    (chk_vld)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int  sweeps;
        logic found;

        rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; load_en = 1'b0; load_adr = '0;
        repeat (3) tick();

        // Reset state
        check("rst_cur_adr",  32'(cur_adr),    32'h0);
        check("rst_data_vld", 32'(data_vld),   32'h0);
        check("rst_running",  32'(running),    32'h0);
        check("rst_sweep",    32'(sweep_done), 32'h0);
        check("rst_chk_vld",  32'(chk_vld),    32'h0);
        check("rst_chk_sum",  32'(chk_sum),    32'h0);

        rst = 1'b0;
        repeat (10) tick();
        check("idle_cur_adr",  32'(cur_adr),    32'h0);
        check("idle_cur_data", 32'(cur_data),   32'h0);
        check("idle_data_vld", 32'(data_vld),   32'h1);
        check("idle_running",  32'(running),    32'h0);
        check("idle_sweep",    32'(sweep_done), 32'h0);

        // Three single steps in PAUSE
        for (int k = 1; k <= 3; k++) begin
            btn_step = 1'b1;
            tick();
            check("step_adr",      32'(ram_adr),  32'(k));
            check("step_vld_low",  32'(data_vld), 32'h0);
            btn_step = 1'b0;
            tick();
            check("step_cur_adr",  32'(cur_adr),  32'(k));
            check("step_cur_data", 32'(cur_data), 32'(k));
            check("step_vld_high", 32'(data_vld), 32'h1);
        end

        // Enter RUN: first advance 4 cycles after the edge cycle
        btn_run = 1'b1;
        tick();
        check("run_running", 32'(running), 32'h1);
        repeat (3) tick();
        check("run_hold3", 32'(ram_adr), 32'h3);
        tick();
        check("run_adv4", 32'(ram_adr), 32'h4);

        // Step pulse while running is ignored
        btn_step = 1'b1;
        tick();
        btn_step = 1'b0;
        repeat (2) tick();
        check("run_step_ign", 32'(ram_adr), 32'h4);
        tick();
        check("run_adv5", 32'(ram_adr), 32'h5);

        // Run up to the wrap (59 advances * 4 cycles = 236 cycles)
        sweeps = 0;
        found  = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            tick();
            if (sweep_done) sweeps++;
            if (ram_adr == 6'h0) found = 1'b1;
        end
        check("wrap_reached", 32'(found),  32'h1);
        check("wrap_pulse",   32'(sweeps), 32'h1);
`ifdef RAM_SCAN_CHECKSUM_EN
        check("wrap_chk_sum", 32'(chk_sum), 32'hE0);
        check("wrap_chk_vld", 32'(chk_vld), 32'h1);
`else
        check("wrap_chk_sum", 32'(chk_sum), 32'h0);
        check("wrap_chk_vld", 32'(chk_vld), 32'h0);
`endif
        repeat (3) begin
            tick();
            if (sweep_done) sweeps++;
        end
        check("wrap_once",    32'(sweeps),  32'h1);
        check("wrap_running", 32'(running), 32'h1);

        // Load during RUN
        load_adr = 6'h2A;
        load_en  = 1'b1;
        tick();
        check("load_running", 32'(running), 32'h0);
        check("load_adr",     32'(ram_adr), 32'h2A);
        load_en = 1'b0;
        tick();
        check("load_cur_adr",  32'(cur_adr),  32'h2A);
        check("load_cur_data", 32'(cur_data), 32'hA);
        check("load_chk_vld",  32'(chk_vld),  32'h0);

        // Load to address 0 must not pulse sweep_done
        load_adr = 6'h0;
        load_en  = 1'b1;
        tick();
        check("load0_sweep", 32'(sweep_done), 32'h0);
        check("load0_adr",   32'(ram_adr),    32'h0);
        load_en = 1'b0;
        btn_run = 1'b0;
        repeat (2) tick();
        check("load0_pause", 32'(running), 32'h0);

        // Simultaneous run and step edges in PAUSE: toggle only
        btn_run  = 1'b1;
        btn_step = 1'b1;
        tick();
        check("both_running", 32'(running), 32'h1);
        check("both_adr",     32'(ram_adr), 32'h0);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        tick();
        check("both_adr_hold", 32'(ram_adr), 32'h0);

        // Second run edge returns to PAUSE
        btn_run = 1'b1;
        tick();
        check("toggle_pause", 32'(running), 32'h0);
        repeat (6) tick();
        check("pause_hold", 32'(ram_adr), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_m_ram_scanner
`default_nettype wire
